// File: rtl/clm_state_decoder.sv
// CLM state decoder: strips the refresh/mask part of 16 CLM codewords and
// assembles the recovered plain bytes into a 128-bit state behind a valid/ready handshake.
module clm_state_decoder #(
  parameter int d = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [0:d-1][0:7]   B_dec,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:7+d]        in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:15][0:7]    out_block,
  output logic                frame_err
);

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              wr_en;
  logic              err_nxt;
  logic              accept;
  logic [0:7]        x_p0;
  logic [0:15][0:7]  blk_p1;

  // Each set mask bit j folds row j of the code matrix back out of the data part.
  function automatic logic [0:7] clm_decode(input logic [0:7+d]      cw,
                                            input logic [0:d-1][0:7] b);
    logic [0:7] x;
    x = cw[0:7];
    for (int j = 0; j < d; j++) begin
      if (cw[8+j]) x = x ^ b[j];
    end
    return x;
  endfunction

  // Stage p0: combinational decode of the incoming codeword
  assign x_p0 = clm_decode(in_data, B_dec);

  // Handshake flags depend on state only; rst_n gating keeps in_ready low during reset
  assign in_ready  = rst_n && (state == COLLECT);
  assign out_valid = (state == OUTPUT);
  assign accept    = in_valid && in_ready;
  assign out_block = blk_p1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (in_last && (cnt == 4'd15)) begin
            wr_en     = 1'b1;
            cnt_nxt   = 4'd0;
            state_nxt = OUTPUT;
          end else if (in_last || (cnt == 4'd15)) begin
            // Framing violation: drop the byte and the partial block
            cnt_nxt = 4'd0;
            err_nxt = 1'b1;
          end else begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      OUTPUT: begin
        if (out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Stage p1: block buffer and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= 4'd0;
      frame_err <= 1'b0;
      blk_p1    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_err <= err_nxt;
      if (wr_en) blk_p1[cnt] <= x_p0;
    end
  end

endmodule

// File: tb/tb_clm_state_decoder.sv
// Randomized self-checking bench for clm_state_decoder with a queue-based reference
// model and a few hand-computed directed blocks.
module tb_clm_state_decoder;
  localparam int D = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [0:D-1][0:7]   B_dec;
  logic                in_valid;
  logic                in_ready;
  logic [0:7+D]        in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [0:15][0:7]    out_block;
  logic                frame_err;

  always #5 clk = ~clk;

  clm_state_decoder #(.d(D)) dut (
    .clk(clk), .rst_n(rst_n), .B_dec(B_dec),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [7:0]   data;
    logic [D-1:0] r;
    bit           last;
  } beat_t;

  beat_t      beats[$];
  logic [7:0] bmat[D];
  int         checks = 0;
  int         errors = 0;
  bit         gap_en = 0;
  bit         rdy_rand = 0;
  bit         rdy_req = 1;
  bit         started = 0;
  int         err_seen = 0;
  int         ov_seen = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = out_block[k][i];
    return b;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [7:0] data, input logic [D-1:0] r);
    logic [7:0] x;
    x = data;
    for (int j = 0; j < D; j++) if (r[j]) x = x ^ bmat[j];
    return x;
  endfunction

  task automatic apply_b();
    for (int j = 0; j < D; j++)
      for (int i = 0; i < 8; i++) B_dec[j][i] = bmat[j][i];
  endtask

  task automatic push_beat(input logic [7:0] data, input logic [D-1:0] r, input bit last);
    beat_t b;
    b.data = data; b.r = r; b.last = last;
    beats.push_back(b);
  endtask

  // Reference model: a queue of decoded bytes for the block in progress
  logic [7:0] m_q[$];
  logic [7:0] m_blk[16];
  bit         m_hold = 0;
  bit         m_err = 0;
  logic [7:0] md, mx;
  logic [D-1:0] mr;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_hold = 0;
      m_err = 0;
      foreach (m_blk[k]) m_blk[k] = 8'h00;
      started = 1;
    end else begin
      m_err = 0;
      if (m_hold) begin
        if (out_ready) m_hold = 0;
      end else if (in_valid) begin
        for (int i = 0; i < 8; i++) md[i] = in_data[i];
        for (int j = 0; j < D; j++) mr[j] = in_data[8+j];
        mx = ref_decode(md, mr);
        if (m_q.size() == 15 && in_last) begin
          m_q.push_back(mx);
          for (int k = 0; k < 16; k++) m_blk[k] = m_q[k];
          m_q.delete();
          m_hold = 1;
        end else if (m_q.size() == 15 || in_last) begin
          m_q.delete();
          m_err = 1;
        end else begin
          m_q.push_back(mx);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, rst_n && !m_hold);
      chk("out_valid", out_valid, m_hold);
      chk("frame_err", frame_err, m_err);
      if (m_hold)
        for (int k = 0; k < 16; k++) chk($sformatf("out_block[%0d]", k), get_byte(k), m_blk[k]);
    end
  end

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_seen++;
    if (out_valid === 1'b1) ov_seen++;
  end

  always @(negedge clk) out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_req;

  // Source: holds a presented codeword until it is accepted
  initial begin
    bit acc;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    forever begin
      @(negedge clk);
      acc = in_valid && in_ready && rst_n;
      @(posedge clk);
      #1;
      if (acc) void'(beats.pop_front());
      if (beats.size() == 0) begin
        in_valid = 1'b0;
      end else if (in_valid && !acc) begin
        in_valid = 1'b1;
      end else if (!gap_en || $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 8; i++) in_data[i] = beats[0].data[i];
        for (int j = 0; j < D; j++) in_data[8+j] = beats[0].r[j];
        in_last  = beats[0].last;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((beats.size() != 0 || in_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_in_budget", n < budget, 1);
  endtask

  task automatic wait_ov(input int budget);
    int n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_in_budget", n < budget, 1);
  endtask

  task automatic take_block(input logic [7:0] exp[16], input string tag);
    wait_ov(300);
    for (int k = 0; k < 16; k++) chk($sformatf("%s_byte%0d", tag, k), get_byte(k), exp[k]);
    @(posedge clk); #2 rdy_req = 1;
    @(negedge clk);
    @(posedge clk); #2 rdy_req = 0;
    @(negedge clk);
  endtask

  task automatic push_plain_block(input logic [7:0] base, output logic [7:0] exp[16]);
    for (int k = 0; k < 16; k++) begin
      push_beat(base + 8'(k), '0, k == 15);
      exp[k] = base + 8'(k);
    end
  endtask

  initial begin
    logic [7:0] exp[16];
    logic [7:0] tbl[4];
    int e0, v0, mode, len, pos;
    tbl[0] = 8'h00; tbl[1] = 8'h1B; tbl[2] = 8'h36; tbl[3] = 8'h2D;
    bmat[0] = 8'h1B; bmat[1] = 8'h36;
    apply_b();

    @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_block", out_block, '0);
    chk("reset_frame_err", frame_err, 0);
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);

    // All-0x53 block, consumer always ready
    for (int k = 0; k < 16; k++) push_beat(8'h53, '0, k == 15);
    wait_ov(100);
    for (int k = 0; k < 16; k++) chk($sformatf("b53_byte%0d", k), get_byte(k), 8'h53);
    @(negedge clk);
    chk("b53_in_ready_back", in_ready, 1);
    chk("b53_out_valid_drop", out_valid, 0);
    wait_idle(100);

    // Mask bits cycling through 00,01,10,11
    @(posedge clk); #2 rdy_req = 0;
    for (int k = 0; k < 16; k++) begin
      push_beat(8'h10 + 8'(k), 2'(k % 4), k == 15);
      exp[k] = (8'h10 + 8'(k)) ^ tbl[k % 4];
    end
    take_block(exp, "mask");

    // Backpressure: consumer stalls, source keeps the next block's first codeword valid
    push_plain_block(8'h80, exp);
    for (int k = 0; k < 16; k++) push_beat(8'hA0 + 8'(k), '0, k == 15);
    wait_ov(200);
    repeat (5) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_no_consume", beats.size(), 16);
      chk("stall_byte0", get_byte(0), 8'h80);
      @(negedge clk);
    end
    @(posedge clk); #2 rdy_req = 1;
    @(negedge clk);
    chk("hs_out_valid", out_valid, 1);
    @(posedge clk); #2 rdy_req = 0;
    @(negedge clk);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_not_yet_consumed", beats.size(), 16);
    @(negedge clk);
    chk("hs_byte0_consumed", beats.size(), 15);
    for (int k = 0; k < 16; k++) exp[k] = 8'hA0 + 8'(k);
    take_block(exp, "after_stall");

    // Early in_last on the 5th codeword
    e0 = err_seen; v0 = ov_seen;
    for (int k = 0; k < 5; k++) push_beat(8'h60 + 8'(k), '0, k == 4);
    push_plain_block(8'hC0, exp);
    take_block(exp, "after_early_last");
    chk("early_last_err_pulses", err_seen - e0, 1);
    chk("early_last_ov_cycles", ov_seen - v0, 2);

    // Missing in_last on the 16th codeword
    e0 = err_seen; v0 = ov_seen;
    for (int k = 0; k < 16; k++) push_beat(8'h70 + 8'(k), '0, 1'b0);
    push_plain_block(8'h30, exp);
    take_block(exp, "after_missing_last");
    chk("missing_last_err_pulses", err_seen - e0, 1);
    chk("missing_last_ov_cycles", ov_seen - v0, 2);

    // Reset mid-block after 9 accepts
    for (int k = 0; k < 9; k++) push_beat(8'hE0 + 8'(k), '0, 1'b0);
    wait_idle(100);
    @(posedge clk); #2 rst_n = 0;
    @(negedge clk);
    chk("midrst_in_ready_low", in_ready, 0);
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_block", out_block, '0);
    chk("midrst_in_ready", in_ready, 1);
    push_plain_block(8'h40, exp);
    take_block(exp, "after_midrst");

    // Reset while a block is waiting for the consumer
    push_plain_block(8'h50, exp);
    wait_ov(200);
    @(posedge clk); #2 rst_n = 0;
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    chk("outrst_out_valid", out_valid, 0);
    chk("outrst_out_block", out_block, '0);
    push_plain_block(8'h20, exp);
    take_block(exp, "after_outrst");

    // Randomized blocks with gaps, random backpressure and occasional framing faults
    gap_en = 1;
    rdy_rand = 1;
    for (int blk = 0; blk < 40; blk++) begin
      if (blk % 8 == 0) begin
        wait_idle(2000);
        bmat[0] = 8'($urandom); bmat[1] = 8'($urandom);
        apply_b();
      end
      mode = $urandom_range(0, 9);
      pos = $urandom_range(0, 14);
      len = (mode == 0) ? pos + 1 : 16;
      for (int k = 0; k < len; k++)
        push_beat(8'($urandom), 2'($urandom), (mode == 1) ? 1'b0 : (k == len - 1));
    end
    wait_idle(5000);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
